entrada_tempo: RTL and testbench

//   Keypad time-entry and run-control front end for the microwave timer.

---
 rtl/microwave_pkg.sv | 33 +++
 rtl/registrador_digitos.sv | 47 ++++
 rtl/entrada_tempo.sv | 131 +++++++++++++
 tb/tb_entrada_tempo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad/timer front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package microwave_pkg;

    // Width of one BCD digit on the load bus.
    localparam int BCD_W = 4;

    // Default largest legal tens-of-seconds digit when starting a cook.
    localparam int MAX_TENS_DEF = 5;

    // Default number of digits accepted per entry (m:ss).
    localparam int MAX_DIGITS_DEF = 3;

    // Highest key code that is a real decimal digit; anything above is rejected.
    localparam logic [BCD_W-1:0] ILLEGAL_CODE = 4'd9;

    // Run-control states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // True when a key code is a decimal digit 0-9.
    function automatic logic is_digit(input logic [BCD_W-1:0] code);
        return code <= ILLEGAL_CODE;
    endfunction

endpackage

// File: rtl/registrador_digitos.sv
// Three-digit BCD shift register with digit counter for keypad time entry.
// Latency: shifted/cleared value visible the cycle after the shift/clr strobe.
// Backpressure: none; caller must not shift while full (full is a status output).
module registrador_digitos
    import microwave_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             shift,
    input  logic             clr,
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] ent_us,
    output logic [BCD_W-1:0] ent_ds,
    output logic [BCD_W-1:0] ent_m,
    output logic             full
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [CW-1:0] count;

    // Digits enter at the units end and move up towards minutes; clr wins over shift.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            ent_us <= '0;
            ent_ds <= '0;
            ent_m  <= '0;
            count  <= '0;
        end else if (clr) begin
            ent_us <= '0;
            ent_ds <= '0;
            ent_m  <= '0;
            count  <= '0;
        end else if (shift) begin
            ent_m  <= ent_ds;
            ent_ds <= ent_us;
            ent_us <= digit;
            count  <= count + 1'b1;
        end
    end

    // Entry is complete once every digit position has been keyed.
    assign full = (count == CW'(MAX_DIGITS));

endmodule

// File: rtl/entrada_tempo.sv
// Keypad time entry and run control: collects m:ss, validates, drives counter load/enable.
// Latency: start accepted at edge t -> load high in cycle t+1 -> enable high from t+2.
// Backpressure: none; strobes resolved cancel > start > digit, losers dropped silently.
module entrada_tempo
    import microwave_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int MAX_TENS   = MAX_TENS_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    input  logic             start_key,
    input  logic             cancel_key,
    input  logic             timer_zero,
    output logic [BCD_W-1:0] ent_us,
    output logic [BCD_W-1:0] ent_ds,
    output logic [BCD_W-1:0] ent_m,
    output logic             load,
    output logic             enable,
    output logic             done_pulse,
    output logic             err_pulse
);

    state_t state;
    state_t state_nxt;
    logic   shift;
    logic   clr;
    logic   err_nxt;
    logic   full;
    logic   value_bad;

    registrador_digitos #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_digitos (
        .clk    (clk),
        .clear  (clear),
        .shift  (shift),
        .clr    (clr),
        .digit  (key_digit),
        .ent_us (ent_us),
        .ent_ds (ent_ds),
        .ent_m  (ent_m),
        .full   (full)
    );

    // A cook cannot start on 0:00 or with more than MAX_TENS tens of seconds.
    assign value_bad = (ent_ds > BCD_W'(MAX_TENS)) ||
                       ((ent_m == '0) && (ent_ds == '0) && (ent_us == '0));

    // Next-state and digit-register control; cancel beats start beats digit.
    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        clr       = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE, ENTRY: begin
                if (cancel_key) begin
                    // Cancel in IDLE is a no-op; in ENTRY it discards the entry.
                    if (state == ENTRY) begin
                        clr       = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (start_key) begin
                    // Start in IDLE is ignored since the value is 0:00 there.
                    if (state == ENTRY) begin
                        if (value_bad) begin
                            err_nxt = 1'b1;
                        end else begin
                            state_nxt = LOAD;
                        end
                    end
                end else if (key_valid) begin
                    if (!is_digit(key_digit) || full) begin
                        err_nxt = 1'b1;
                    end else begin
                        shift     = 1'b1;
                        state_nxt = ENTRY;
                    end
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                // Reaching zero ends the cook even if cancel arrives the same cycle.
                if (timer_zero) begin
                    state_nxt = DONE;
                end else if (cancel_key) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (cancel_key) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end else if (start_key) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                clr       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                clr       = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state      <= IDLE;
            load       <= 1'b0;
            enable     <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_nxt;
            load       <= (state_nxt == LOAD);
            enable     <= (state_nxt == RUN);
            done_pulse <= (state_nxt == DONE);
            err_pulse  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_entrada_tempo.sv
module tb_entrada_tempo;

    logic       clk;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start_key;
    logic       cancel_key;
    logic       timer_zero;
    logic [3:0] ent_us;
    logic [3:0] ent_ds;
    logic [3:0] ent_m;
    logic       load;
    logic       enable;
    logic       done_pulse;
    logic       err_pulse;

    entrada_tempo dut (
        .clk        (clk),
        .clear      (clear),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .start_key  (start_key),
        .cancel_key (cancel_key),
        .timer_zero (timer_zero),
        .ent_us     (ent_us),
        .ent_ds     (ent_ds),
        .ent_m      (ent_m),
        .load       (load),
        .enable     (enable),
        .done_pulse (done_pulse),
        .err_pulse  (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: entry held as a decimal number 0..999, phase as a small int.
    localparam int P_IDLE  = 0;
    localparam int P_ENTRY = 1;
    localparam int P_LOAD  = 2;
    localparam int P_RUN   = 3;
    localparam int P_PAUSE = 4;
    localparam int P_DONE  = 5;

    int mv;
    int mc;
    int mp;
    bit m_err;

    typedef struct {
        bit kv;
        int kd;
        bit st;
        bit cn;
        bit tz;
        int us;
        int ds;
        int m;
        bit ld;
        bit en;
        bit dn;
        bit er;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int us, input int ds, input int m,
                           input bit ld, input bit en, input bit dn, input bit er);
        chk({tag, " ent_us"}, int'(ent_us), us);
        chk({tag, " ent_ds"}, int'(ent_ds), ds);
        chk({tag, " ent_m"}, int'(ent_m), m);
        chk({tag, " load"}, int'(load), int'(ld));
        chk({tag, " enable"}, int'(enable), int'(en));
        chk({tag, " done_pulse"}, int'(done_pulse), int'(dn));
        chk({tag, " err_pulse"}, int'(err_pulse), int'(er));
    endtask

    task automatic model_reset();
        mv = 0; mc = 0; mp = P_IDLE; m_err = 1'b0;
    endtask

    task automatic model_step(input bit kv, input int kd, input bit st, input bit cn, input bit tz);
        m_err = 1'b0;
        case (mp)
            P_IDLE, P_ENTRY: begin
                if (cn) begin
                    if (mp == P_ENTRY) begin mv = 0; mc = 0; mp = P_IDLE; end
                end else if (st) begin
                    if (mp == P_ENTRY) begin
                        if (((mv / 10) % 10) > 5 || mv == 0) m_err = 1'b1;
                        else mp = P_LOAD;
                    end
                end else if (kv) begin
                    if (kd > 9 || mc >= 3) m_err = 1'b1;
                    else begin mv = (mv * 10 + kd) % 1000; mc++; mp = P_ENTRY; end
                end
            end
            P_LOAD:  mp = P_RUN;
            P_RUN: begin
                if (tz) mp = P_DONE;
                else if (cn) mp = P_PAUSE;
            end
            P_PAUSE: begin
                if (cn) begin mv = 0; mc = 0; mp = P_IDLE; end
                else if (st) mp = P_RUN;
            end
            default: begin mv = 0; mc = 0; mp = P_IDLE; end
        endcase
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, mv % 10, (mv / 10) % 10, mv / 100,
                mp == P_LOAD, mp == P_RUN, mp == P_DONE, m_err);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1 ns later.
    task automatic drive(input bit kv, input int kd, input bit st, input bit cn, input bit tz);
        key_valid  = kv;
        key_digit  = 4'(kd);
        start_key  = st;
        cancel_key = cn;
        timer_zero = tz;
        @(posedge clk);
        model_step(kv, kd, st, cn, tz);
        #1;
    endtask

    task automatic add(input bit kv, input int kd, input bit st, input bit cn, input bit tz,
                       input int us, input int ds, input int m,
                       input bit ld, input bit en, input bit dn, input bit er);
        vec_t v;
        v.kv = kv; v.kd = kd; v.st = st; v.cn = cn; v.tz = tz;
        v.us = us; v.ds = ds; v.m = m; v.ld = ld; v.en = en; v.dn = dn; v.er = er;
        tab.push_back(v);
    endtask

    initial begin
        //  kv kd st cn tz   us ds m  ld en dn er
        // keys 1,2,3 then start: 1:23, load one cycle, then enable; zero ends cook
        add(1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0,   2, 1, 0, 0, 0, 0, 0);
        add(1, 3, 0, 0, 0,   3, 2, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   3, 2, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,   3, 2, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,   3, 2, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1,   3, 2, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // keys 9,9 then start: rejected, stays in entry with 0:99
        add(1, 9, 0, 0, 0,   9, 0, 0, 0, 0, 0, 0);
        add(1, 9, 0, 0, 0,   9, 9, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   9, 9, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,   9, 9, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        // keys 4,5,6,7: fourth rejected; 4:56 starts (tens = 5 is legal) and finishes
        add(1, 4, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0,   5, 4, 0, 0, 0, 0, 0);
        add(1, 6, 0, 0, 0,   6, 5, 4, 0, 0, 0, 0);
        add(1, 7, 0, 0, 0,   6, 5, 4, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0,   6, 5, 4, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,   6, 5, 4, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1,   6, 5, 4, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // digit and cancel together in entry: cleared, digit dropped
        add(1, 3, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0);
        add(1, 7, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        // 0:30 run, pause, resume, pause, cancel
        add(1, 3, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   0, 3, 0, 1, 0, 0, 0);
        add(1, 8, 0, 0, 0,   0, 3, 0, 0, 1, 0, 0);
        add(1, 2, 0, 0, 0,   0, 3, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0,   0, 3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   0, 3, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0,   0, 3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        // illegal code in idle, then start in idle is ignored
        add(1, 12, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);

        key_valid = 0; key_digit = 0; start_key = 0; cancel_key = 0; timer_zero = 0;
        clear = 1'b0;
        model_reset();
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        #10;
        clear = 1'b1;

        foreach (tab[i]) begin
            drive(tab[i].kv, tab[i].kd, tab[i].st, tab[i].cn, tab[i].tz);
            chk_all($sformatf("vec%0d", i), tab[i].us, tab[i].ds, tab[i].m,
                    tab[i].ld, tab[i].en, tab[i].dn, tab[i].er);
        end

        // Asynchronous reset in the middle of a run.
        drive(1, 2, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("arst pre enable", int'(enable), 1);
        #3;
        clear = 1'b0;
        #1;
        chk_all("arst during", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #4;
        clear = 1'b1;
        model_reset();
        drive(1, 5, 0, 0, 0);
        chk_all("arst after key", 5, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk_all("arst after start", 5, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk_model("arst run");
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk_model("arst cleanup");

        // Randomised traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit kv, st, cn, tz;
            int kd;
            kv = ($urandom_range(0, 1) == 1);
            kd = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            st = ($urandom_range(0, 4) == 0);
            cn = ($urandom_range(0, 11) == 0);
            tz = ($urandom_range(0, 7) == 0);
            drive(kv, kd, st, cn, tz);
            chk_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
